key_edge_detect: RTL and testbench

//   Front end of the key path and the source side of the H2L_Sig/L2H_Sig

---
 rtl/key_edge_detect.sv | 120 ++++++++++++
 tb/tb_key_edge_detect.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/key_edge_detect.sv
// Key pin synchroniser with power-up inhibit, one-cycle press/release pulses
// and a post-pulse lockout that suppresses contact bounce.
module key_edge_detect #(
  parameter logic [15:0] T1MS    = 16'd49_999,
  parameter logic [12:0] T100US  = 13'd4_999,
  parameter logic [3:0]  LOCK_MS = 4'd10
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Pin_In,
  output logic H2L_Sig,
  output logic L2H_Sig,
  output logic Key_Level,
  output logic Ready
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic        s1_reg, s2_reg;
  logic [12:0] count100_reg, count100_next;
  logic [15:0] count1_reg, count1_next;
  logic [3:0]  count_ms_reg, count_ms_next;
  logic        key_level_reg, key_level_next;
  logic        ready_reg, ready_next;
  logic        h2l_reg, h2l_next;
  logic        l2h_reg, l2h_next;

  // Two-flop synchroniser; idle-high reset value matches an untouched key.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1_reg <= 1'b1;
      s2_reg <= 1'b1;
    end else begin
      s1_reg <= Pin_In;
      s2_reg <= s1_reg;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg     <= INIT;
      count100_reg  <= '0;
      count1_reg    <= '0;
      count_ms_reg  <= '0;
      key_level_reg <= 1'b1;
      ready_reg     <= 1'b0;
      h2l_reg       <= 1'b0;
      l2h_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count100_reg  <= count100_next;
      count1_reg    <= count1_next;
      count_ms_reg  <= count_ms_next;
      key_level_reg <= key_level_next;
      ready_reg     <= ready_next;
      h2l_reg       <= h2l_next;
      l2h_reg       <= l2h_next;
    end
  end

  // Counters default to zero so any state that does not use them keeps them cleared;
  // pulses default to zero so each one lasts a single cycle.
  always_comb begin
    state_next     = state_reg;
    count100_next  = '0;
    count1_next    = '0;
    count_ms_next  = '0;
    key_level_next = key_level_reg;
    ready_next     = ready_reg;
    h2l_next       = 1'b0;
    l2h_next       = 1'b0;

    case (state_reg)
      INIT: begin
        if (count100_reg == T100US) begin
          ready_next     = 1'b1;
          key_level_next = s2_reg;
          state_next     = IDLE;
        end else begin
          count100_next = count100_reg + 13'd1;
        end
      end

      IDLE: begin
        if (s2_reg != key_level_reg) begin
          key_level_next = s2_reg;
          state_next     = LOCK;
          h2l_next       = ~s2_reg;
          l2h_next       = s2_reg;
        end
      end

      LOCK: begin
        if (count1_reg == T1MS) begin
          if (count_ms_reg == LOCK_MS - 4'd1) begin
            state_next = IDLE;
          end else begin
            count_ms_next = count_ms_reg + 4'd1;
          end
        end else begin
          count1_next   = count1_reg + 16'd1;
          count_ms_next = count_ms_reg;
        end
      end

      default: state_next = INIT;
    endcase
  end

  assign H2L_Sig   = h2l_reg;
  assign L2H_Sig   = l2h_reg;
  assign Key_Level = key_level_reg;
  assign Ready     = ready_reg;

endmodule

// File: tb/tb_key_edge_detect.sv
// Directed bench for key_edge_detect with shortened timing
// (T1MS=9, T100US=19, LOCK_MS=2 -> 20-cycle lockout).
module tb_key_edge_detect;

  logic CLK;
  logic RSTn;
  logic Pin_In;
  logic H2L_Sig;
  logic L2H_Sig;
  logic Key_Level;
  logic Ready;

  int n_checks;
  int n_fail;

  key_edge_detect #(
    .T1MS    (16'd9),
    .T100US  (13'd19),
    .LOCK_MS (4'd2)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Pin_In    (Pin_In),
    .H2L_Sig   (H2L_Sig),
    .L2H_Sig   (L2H_Sig),
    .Key_Level (Key_Level),
    .Ready     (Ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance past the next rising edge; outputs are stable 1 ns later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Power-up with key idle: Ready at edge 20, no pulses, Key_Level stays 1.
  task automatic test_reset();
    logic [1:0] exp_p;
    Pin_In = 1'b1;
    RSTn   = 1'b1;
    #2;
    RSTn = 1'b0;
    step();
    step();
    n_checks++;
    if ({H2L_Sig, L2H_Sig, Ready, Key_Level} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_values: got %b want 0001", {H2L_Sig, L2H_Sig, Ready, Key_Level});
    end
    RSTn = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      step();
      exp_p = 2'b00;
      n_checks++;
      if ({H2L_Sig, L2H_Sig} !== exp_p) begin
        n_fail++;
        $display("FAIL reset_pulses e=%0d: got %b want %b", e, {H2L_Sig, L2H_Sig}, exp_p);
      end
      n_checks++;
      if (Ready !== (e >= 20)) begin
        n_fail++;
        $display("FAIL reset_ready e=%0d: got %b want %b", e, Ready, (e >= 20));
      end
      n_checks++;
      if (Key_Level !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_key_level e=%0d: got %b want 1", e, Key_Level);
      end
    end
    $display("test_reset done");
  endtask

  // Press at edge 1, hold 40 cycles, release at edge 41: H2L at 3, L2H at 43.
  task automatic test_press_hold_release();
    logic [1:0] exp_p;
    logic       exp_k;
    for (int e = 1; e <= 70; e++) begin
      Pin_In = (e >= 41);
      step();
      exp_p = (e == 3) ? 2'b10 : (e == 43) ? 2'b01 : 2'b00;
      exp_k = (e >= 3 && e < 43) ? 1'b0 : 1'b1;
      n_checks++;
      if ({H2L_Sig, L2H_Sig} !== exp_p) begin
        n_fail++;
        $display("FAIL press_hold_pulses e=%0d: got %b want %b", e, {H2L_Sig, L2H_Sig}, exp_p);
      end
      n_checks++;
      if (Key_Level !== exp_k) begin
        n_fail++;
        $display("FAIL press_hold_key_level e=%0d: got %b want %b", e, Key_Level, exp_k);
      end
    end
    $display("test_press_hold_release done");
  endtask

  // Press then 5 toggles ending high inside the lockout: one H2L at edge 3,
  // catch-up L2H on the first IDLE edge after the 20-cycle lock (edge 24).
  task automatic test_bounce();
    logic [1:0] exp_p;
    logic       exp_k;
    for (int e = 1; e <= 50; e++) begin
      if (e == 1) Pin_In = 1'b0;
      else if (e >= 3 && e <= 7) Pin_In = ~Pin_In;
      step();
      exp_p = (e == 3) ? 2'b10 : (e == 24) ? 2'b01 : 2'b00;
      exp_k = (e >= 3 && e < 24) ? 1'b0 : 1'b1;
      n_checks++;
      if ({H2L_Sig, L2H_Sig} !== exp_p) begin
        n_fail++;
        $display("FAIL bounce_pulses e=%0d: got %b want %b", e, {H2L_Sig, L2H_Sig}, exp_p);
      end
      n_checks++;
      if (Key_Level !== exp_k) begin
        n_fail++;
        $display("FAIL bounce_key_level e=%0d: got %b want %b", e, Key_Level, exp_k);
      end
    end
    $display("test_bounce done");
  endtask

  // Reset asserted partway through LOCK with the key still held low.
  task automatic test_reset_mid_lock();
    logic [1:0] exp_p;
    for (int e = 1; e <= 9; e++) begin
      if (e == 1) Pin_In = 1'b0;
      step();
      exp_p = (e == 3) ? 2'b10 : 2'b00;
      n_checks++;
      if ({H2L_Sig, L2H_Sig} !== exp_p) begin
        n_fail++;
        $display("FAIL midlock_press e=%0d: got %b want %b", e, {H2L_Sig, L2H_Sig}, exp_p);
      end
    end
    RSTn = 1'b0;
    #1;
    n_checks++;
    if ({H2L_Sig, L2H_Sig, Ready, Key_Level} !== 4'b0001) begin
      n_fail++;
      $display("FAIL midlock_async_reset: got %b want 0001", {H2L_Sig, L2H_Sig, Ready, Key_Level});
    end
    step();
    step();
    RSTn = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      step();
      n_checks++;
      if ({H2L_Sig, L2H_Sig} !== 2'b00) begin
        n_fail++;
        $display("FAIL midlock_restart_pulses e=%0d: got %b want 00", e, {H2L_Sig, L2H_Sig});
      end
      n_checks++;
      if ({Ready, Key_Level} !== ((e >= 20) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL midlock_restart_ready_level e=%0d: got %b want %b", e, {Ready, Key_Level},
                 ((e >= 20) ? 2'b10 : 2'b01));
      end
    end
    $display("test_reset_mid_lock done");
  endtask

  // Key held low through reset and INIT: Key_Level=0, never an H2L.
  // Releasing afterwards gives a normal L2H.
  task automatic test_held_through_reset();
    logic [1:0] exp_p;
    Pin_In = 1'b0;
    RSTn   = 1'b0;
    step();
    step();
    RSTn = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      step();
      n_checks++;
      if ({H2L_Sig, L2H_Sig} !== 2'b00) begin
        n_fail++;
        $display("FAIL held_init_pulses e=%0d: got %b want 00", e, {H2L_Sig, L2H_Sig});
      end
      n_checks++;
      if ({Ready, Key_Level} !== ((e >= 20) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL held_init_ready_level e=%0d: got %b want %b", e, {Ready, Key_Level},
                 ((e >= 20) ? 2'b10 : 2'b01));
      end
    end
    for (int e = 1; e <= 30; e++) begin
      Pin_In = 1'b1;
      step();
      exp_p = (e == 3) ? 2'b01 : 2'b00;
      n_checks++;
      if ({H2L_Sig, L2H_Sig} !== exp_p) begin
        n_fail++;
        $display("FAIL held_release_pulses e=%0d: got %b want %b", e, {H2L_Sig, L2H_Sig}, exp_p);
      end
      n_checks++;
      if (Key_Level !== (e >= 3)) begin
        n_fail++;
        $display("FAIL held_release_key_level e=%0d: got %b want %b", e, Key_Level, (e >= 3));
      end
    end
    $display("test_held_through_reset done");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Pin_In   = 1'b1;
    RSTn     = 1'b1;
    test_reset();
    test_press_hold_release();
    test_bounce();
    test_reset_mid_lock();
    test_held_through_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
